// File: rtl/cam_access_ctrl.sv
// Initiator-side controller for a 16-entry CAM: serialises lookup/write requests onto the CAM pins
// and returns one response per request. A validity bitmap masks stale CAM contents.
module cam_access_ctrl #(
    parameter int KEY_W         = 8,
    parameter int ADDR_W        = 4,
    parameter bit ALLOC_ON_MISS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_alloc,
    output logic              cam_wen,
    output logic              cam_ren,
    output logic [KEY_W-1:0]  cam_din,
    output logic [ADDR_W-1:0] cam_addr,
    input  logic [ADDR_W-1:0] cam_dout,
    input  logic              cam_hit
);

    localparam int ENTRIES = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CAPTURE,
        S_ALLOC,
        S_WRITE,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0]   alloc_ptr_q, alloc_ptr_d;

    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic                rsp_alloc_q, rsp_alloc_d;
    logic                cam_wen_q, cam_wen_d;
    logic                cam_ren_q, cam_ren_d;
    logic [KEY_W-1:0]    cam_din_q, cam_din_d;
    logic [ADDR_W-1:0]   cam_addr_q, cam_addr_d;

    logic                eff_hit;

    // A CAM match only counts if the matched slot has been written since reset.
    assign eff_hit = cam_hit & valid_q[cam_dout];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_d     = state_q;
        key_d       = key_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        alloc_ptr_d = alloc_ptr_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_alloc_d = rsp_alloc_q;
        cam_wen_d   = 1'b0;
        cam_ren_d   = 1'b0;
        cam_din_d   = cam_din_q;
        cam_addr_d  = cam_addr_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    key_d     = req_key;
                    addr_d    = req_addr;
                    cam_din_d = req_key;
                    if (req_op) begin
                        state_d    = S_WRITE;
                        cam_wen_d  = 1'b1;
                        cam_addr_d = req_addr;
                    end else begin
                        state_d   = S_LOOKUP;
                        cam_ren_d = 1'b1;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_LOOKUP: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (eff_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_addr_d  = cam_dout;
                    rsp_alloc_d = 1'b0;
                    state_d     = S_RESP;
                end else if (ALLOC_ON_MISS) begin
                    state_d    = S_ALLOC;
                    cam_wen_d  = 1'b1;
                    cam_addr_d = alloc_ptr_q;
                    cam_din_d  = key_q;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b0;
                    rsp_addr_d  = '0;
                    rsp_alloc_d = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_ALLOC: begin
                // Round-robin replacement: the pointer wraps, overwriting the oldest allocation.
                valid_d[alloc_ptr_q] = 1'b1;
                alloc_ptr_d          = alloc_ptr_q + ADDR_W'(1);
                rsp_valid_d          = 1'b1;
                rsp_hit_d            = 1'b0;
                rsp_addr_d           = alloc_ptr_q;
                rsp_alloc_d          = 1'b1;
                state_d              = S_RESP;
            end
            S_WRITE: begin
                valid_d[addr_q] = 1'b1;
                rsp_valid_d     = 1'b1;
                rsp_hit_d       = 1'b1;
                rsp_addr_d      = addr_q;
                rsp_alloc_d     = 1'b0;
                state_d         = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_alloc_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            addr_q      <= '0;
            // NOTE: the validity bitmap is reset (unlike the CAM array) because it defines what is stale.
            valid_q     <= '0;
            alloc_ptr_q <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_alloc_q <= 1'b0;
            cam_wen_q   <= 1'b0;
            cam_ren_q   <= 1'b0;
            cam_din_q   <= '0;
            cam_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            alloc_ptr_q <= alloc_ptr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_alloc_q <= rsp_alloc_d;
            cam_wen_q   <= cam_wen_d;
            cam_ren_q   <= cam_ren_d;
            cam_din_q   <= cam_din_d;
            cam_addr_q  <= cam_addr_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_alloc = rsp_alloc_q;
    assign cam_wen   = cam_wen_q;
    assign cam_ren   = cam_ren_q;
    assign cam_din   = cam_din_q;
    assign cam_addr  = cam_addr_q;

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Bench for cam_access_ctrl: behavioural CAM responder, a system model that predicts each
// response (including latency) into a scoreboard queue, and a response monitor that pops it.
module tb_cam_access_ctrl;

    localparam int KEY_W  = 8;
    localparam int ADDR_W = 4;
    localparam int N      = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_op = 1'b0;
    logic [KEY_W-1:0]  req_key = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic              rsp_hit;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_alloc;
    logic              cam_wen;
    logic              cam_ren;
    logic [KEY_W-1:0]  cam_din;
    logic [ADDR_W-1:0] cam_addr;
    logic [ADDR_W-1:0] cam_dout = '0;
    logic              cam_hit = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    cam_access_ctrl #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .ALLOC_ON_MISS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_addr(rsp_addr), .rsp_alloc(rsp_alloc),
        .cam_wen(cam_wen), .cam_ren(cam_ren), .cam_din(cam_din), .cam_addr(cam_addr),
        .cam_dout(cam_dout), .cam_hit(cam_hit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- CAM responder (contents never reset) ----------------
    logic [KEY_W-1:0] cam_mem [N];

    function automatic logic [ADDR_W:0] cam_match(input logic [KEY_W-1:0] k);
        logic [ADDR_W:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (cam_mem[i] == k) r = {1'b1, ADDR_W'(i)};
        return r;
    endfunction

    always @(posedge clk) begin
        if (cam_ren) {cam_hit, cam_dout} <= cam_match(cam_din);
        else if (cam_wen) cam_mem[cam_addr] <= cam_din;
    end

    // ---------------- System model and scoreboard ----------------
    typedef struct {
        logic              hit;
        logic [ADDR_W-1:0] addr;
        logic              alloc;
        int                lat;
        int                hs;
    } exp_t;

    exp_t              exp_q[$];
    logic [KEY_W-1:0]  m_mem [N];
    logic [N-1:0]      m_valid = '0;
    logic [ADDR_W-1:0] m_ptr = '0;

    task automatic send_req(input logic op, input logic [KEY_W-1:0] key, input logic [ADDR_W-1:0] addr);
        exp_t e;
        int   n;
        int   idx;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_addr  = addr;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.hs = cyc;
        if (op) begin
            m_mem[addr]   = key;
            m_valid[addr] = 1'b1;
            e.hit = 1'b1; e.addr = addr; e.alloc = 1'b0; e.lat = 2;
        end else begin
            idx = -1;
            for (int i = 0; i < N; i++)
                if (m_mem[i] == key) idx = i;
            if (idx >= 0 && m_valid[idx]) begin
                e.hit = 1'b1; e.addr = ADDR_W'(idx); e.alloc = 1'b0; e.lat = 3;
            end else begin
                e.hit = 1'b0; e.addr = m_ptr; e.alloc = 1'b1; e.lat = 4;
                m_mem[m_ptr]   = key;
                m_valid[m_ptr] = 1'b1;
                m_ptr          = m_ptr + 1'b1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {10'd0, req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_alloc, cam_wen, cam_ren, cam_din, cam_addr},
              32'd0);
        exp_q.delete();
        m_valid = '0;
        m_ptr   = '0;
        rst_n   = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    // ---------------- Response monitor ----------------
    logic              in_rsp = 1'b0;
    logic              s_hit;
    logic [ADDR_W-1:0] s_addr;
    logic              s_alloc;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_rsp = 1'b0;
        end else if (rsp_valid) begin
            check("req_ready_in_rsp", {31'd0, req_ready}, 32'd0);
            if (!in_rsp) begin
                in_rsp  = 1'b1;
                s_hit   = rsp_hit;
                s_addr  = rsp_addr;
                s_alloc = rsp_alloc;
                if (exp_q.size() == 0) check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                else check("latency", cyc - exp_q[0].hs, exp_q[0].lat);
            end else begin
                check("hold_stable", {26'd0, rsp_hit, rsp_addr, rsp_alloc}, {26'd0, s_hit, s_addr, s_alloc});
            end
            if (rsp_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_hit", {31'd0, rsp_hit}, {31'd0, e.hit});
                    check("rsp_addr", {28'd0, rsp_addr}, {28'd0, e.addr});
                    check("rsp_alloc", {31'd0, rsp_alloc}, {31'd0, e.alloc});
                end
                in_rsp = 1'b0;
            end
        end
    end

    // ---------------- Stimulus ----------------
    initial begin
        int n;
        int strobes;
        for (int i = 0; i < N; i++) begin
            cam_mem[i] = '0;
            m_mem[i]   = '0;
        end

        do_reset();

        // Lookup of 0 on an all-zero CAM: stale match masked, allocates slot 0.
        send_req(1'b0, 8'h00, 4'h0);
        wait_drain();

        // Write 0x10 to slot C: one-cycle wen strobe with the right address/data.
        send_req(1'b1, 8'h10, 4'hC);
        @(negedge clk);
        check("wr_wen", {31'd0, cam_wen}, 32'd1);
        check("wr_ren", {31'd0, cam_ren}, 32'd0);
        check("wr_addr", {28'd0, cam_addr}, 32'hC);
        check("wr_din", {24'd0, cam_din}, 32'h10);
        @(negedge clk);
        check("wr_wen_off", {31'd0, cam_wen}, 32'd0);
        wait_drain();

        // Lookup 0x10: one-cycle ren strobe, hit at C.
        send_req(1'b0, 8'h10, 4'h0);
        @(negedge clk);
        check("lk_ren", {31'd0, cam_ren}, 32'd1);
        check("lk_din", {24'd0, cam_din}, 32'h10);
        @(negedge clk);
        check("lk_ren_off", {31'd0, cam_ren}, 32'd0);
        wait_drain();

        // Duplicate key at E, 0, 2: highest index wins.
        send_req(1'b1, 8'h30, 4'hE);
        send_req(1'b1, 8'h30, 4'h0);
        send_req(1'b1, 8'h30, 4'h2);
        send_req(1'b0, 8'h30, 4'h0);
        wait_drain();

        // Backpressure: response must hold for 5 cycles.
        rsp_ready = 1'b0;
        send_req(1'b0, 8'h10, 4'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        wait_drain();

        // Seventeen misses wrap the allocation pointer; key 100 is then evicted.
        do_reset();
        for (int k = 100; k <= 116; k++) send_req(1'b0, KEY_W'(k), 4'h0);
        send_req(1'b0, 8'd100, 4'h0);
        send_req(1'b0, 8'd116, 4'h0);
        wait_drain();

        // Reset during LOOKUP: request abandoned, no response and no further strobe.
        send_req(1'b0, 8'h55, 4'h0);
        @(negedge clk);
        check("mid_ren", {31'd0, cam_ren}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs",
              {10'd0, req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_alloc, cam_wen, cam_ren, cam_din, cam_addr},
              32'd0);
        exp_q.delete();
        m_valid = '0;
        m_ptr   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || cam_ren || cam_wen) strobes++;
        end
        check("post_reset_quiet", strobes, 32'd0);

        // Stale top match: 105 lives at stale slot 5 and valid slot 0 -> still a miss.
        send_req(1'b0, 8'd105, 4'h0);
        send_req(1'b0, 8'd105, 4'h0);
        send_req(1'b0, 8'h55, 4'h0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_access_ctrl.md
Name: cam_access_ctrl

Overview:
- Initiator-side controller for the 16-entry, 8-bit Content_Addressable_Memory; the CAM is the responder.
- Accepts lookup and write requests over a valid/ready request channel and drives the CAM pins (wen, ren, din, addr).
- Captures the CAM's registered dout/hit and returns results over a valid/ready response channel.
- Tracks entry validity and optionally allocates a slot on a lookup miss (insert-on-miss).

Parameters:
- KEY_W, 8, CAM data/key width.
- ADDR_W, 4, CAM address width (1<<ADDR_W = 16 entries).
- ALLOC_ON_MISS, 1, 1 = a lookup miss writes the key into the slot at alloc_ptr; 0 = a miss only reports.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_op  input  1  0 = lookup, 1 = write.
- req_key  input  KEY_W  key to search for, or data to write.
- req_addr  input  ADDR_W  write address; ignored for lookup.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_hit  output  1  lookup found a valid entry; always 1 for a write.
- rsp_addr  output  ADDR_W  matched, allocated or written address.
- rsp_alloc  output  1  this lookup miss allocated rsp_addr.
- cam_wen  output  1  to CAM wen.
- cam_ren  output  1  to CAM ren.
- cam_din  output  KEY_W  to CAM din.
- cam_addr  output  ADDR_W  to CAM addr.
- cam_dout  input  ADDR_W  from CAM dout.
- cam_hit  input  1  from CAM hit.

Behaviour:
- Clocking/reset: one clock (clk); reset rst_n is synchronous, active-low.
  - Reset clears all outputs to 0, state to IDLE, valid[15:0] to 0 and alloc_ptr to 0.
  - CAM contents are not cleared; the valid bitmap masks stale entries.
- CAM contract:
  - ren=1 at a posedge registers dout/hit, visible the following cycle.
  - ren has priority over wen; ren=0, wen=1 writes mem[addr]=din.
  - On multiple matches, dout reports the highest matching index.
- FSM states: IDLE, LOOKUP, CAPTURE, ALLOC, WRITE, RESP.
- IDLE:
  - req_ready=1 only in IDLE.
  - On a req_valid&req_ready handshake, latch op, key and addr.
  - op=0 goes to LOOKUP; op=1 goes to WRITE.
- LOOKUP (1 cycle): cam_ren=1, cam_wen=0, cam_din=key. Next state CAPTURE.
- CAPTURE (1 cycle): sample cam_hit/cam_dout.
  - Effective hit = cam_hit & valid[cam_dout].
  - On hit: rsp_hit=1, rsp_addr=cam_dout, go to RESP.
  - On miss with ALLOC_ON_MISS=1: go to ALLOC.
  - On miss with ALLOC_ON_MISS=0: rsp_hit=0, rsp_addr=0, go to RESP.
- ALLOC (1 cycle):
  - cam_wen=1, cam_ren=0, cam_addr=alloc_ptr, cam_din=key.
  - Set valid[alloc_ptr]; rsp_hit=0, rsp_alloc=1, rsp_addr=alloc_ptr.
  - alloc_ptr increments and wraps 15 to 0; the oldest entry is overwritten when all 16 are valid.
  - Next state RESP.
- WRITE (1 cycle):
  - cam_wen=1, cam_ren=0, cam_addr=req_addr, cam_din=key.
  - Set valid[req_addr]; alloc_ptr is unchanged.
  - rsp_hit=1, rsp_alloc=0, rsp_addr=req_addr. Next state RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1, then return to IDLE. rsp_alloc is cleared on return.
  - No new request is accepted while in RESP; exactly one request is outstanding at a time.
- CAM pin defaults: cam_wen and cam_ren are 0 outside their states; cam_din/cam_addr hold their last values.
- Latency with rsp_ready held high, handshake to rsp_valid:
  - lookup hit: 3 cycles (LOOKUP, CAPTURE, RESP);
  - lookup miss with alloc: 4 cycles;
  - write: 2 cycles.
- Duplicate keys: the highest valid index wins only if the CAM's top match is valid; a stale top match reads as a miss and allocates a slot.
- Reset mid-operation: the request is abandoned, no response is issued, and no further CAM strobe follows.

Test Plan:
- Reset then a write request (key=10, addr=C) -> cam_wen pulses 1 cycle with addr=C, din=10; response hit=1, addr=C, alloc=0.
- Lookup key=10 after the above -> cam_ren for 1 cycle; response hit=1, addr=C, 3 cycles after the handshake.
- Writes of key=30 to E, 0, 2, then lookup 30 -> response hit=1, addr=E (highest index).
- After reset, lookup key=0 with CAM memory all 0 -> masked by valid; response hit=0, alloc=1, addr=0; alloc_ptr becomes 1.
- 17 consecutive misses with distinct keys 100..116 -> addrs 0..15 then 0 again; the first key (100) no longer hits.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stay stable and req_ready=0 throughout; assert rst_n=0 during LOOKUP -> no response, all outputs 0.
